// File: rtl/mem_op_pkg.sv
// Shared definitions for mem_op_unit: access-size encodings, FSM state type and
// byte-enable / alignment helpers.
package mem_op_pkg;

    localparam logic [1:0] SizeByte  = 2'd0;
    localparam logic [1:0] SizeHalf  = 2'd1;
    localparam logic [1:0] SizeWord  = 2'd2;
    localparam logic [1:0] SizeDword = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StWait  = 2'd2;
    localparam state_t StResp  = 2'd3;

    // Byte-enable pattern for an access of the given size at lane 0.
    function automatic logic [7:0] be_mask(input logic [1:0] size);
        case (size)
            SizeByte: be_mask = 8'h01;
            SizeHalf: be_mask = 8'h03;
            SizeWord: be_mask = 8'h0F;
            default:  be_mask = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_lsb_mask(input logic [1:0] size);
        case (size)
            SizeByte: size_lsb_mask = 3'd0;
            SizeHalf: size_lsb_mask = 3'd1;
            SizeWord: size_lsb_mask = 3'd3;
            default:  size_lsb_mask = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_op_if.sv
// Pipeline request/response and memory-port signals of mem_op_unit.
// The unit uses the slave modport; the pipeline/memory environment uses master.
interface mem_op_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_exc;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_byteen;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        output rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc,
        input  mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        input  rsp_ready, mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc,
        output mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
    );

endinterface

// File: rtl/lane_align.sv
// Load-path lane selection: right-justifies the addressed lane of a memory word and
// sign- or zero-extends it to the full data width.
module lane_align import mem_op_pkg::*; #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = 2
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] fill;
    logic              sign;

    always_comb begin
        shifted = data >> {off, 3'b000};
        // A shift by >= DATA_W clears everything, so full-width accesses keep all bits.
        keep    = ~({DATA_W{1'b1}} << (8 << size));
        case (size)
            SizeByte: sign = shifted[7];
            SizeHalf: sign = shifted[15];
            SizeWord: sign = shifted[31];
            default:  sign = shifted[DATA_W-1];
        endcase
        fill   = {DATA_W{sign & ~uns}};
        result = (shifted & keep) | (fill & ~keep);
    end

endmodule

// File: rtl/mem_op_unit.sv
// mem_op_unit: single-outstanding load/store unit between a pipeline and a byte-lane memory port.
// Define MISALIGN_EXC_EN to raise an exception on unaligned accesses instead of aligning them down.
module mem_op_unit import mem_op_pkg::*; #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input logic     clk,
    input logic     reset,
    mem_op_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    state_t            state_q, state_d;
    logic              we_q, uns_q, exc_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   byteen_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, load_data;

    logic              accept, req_exc;
    logic [OFF_W-1:0]  req_off, size_msk, align_off;
    logic [BE_W-1:0]   req_byteen;
    logic [DATA_W-1:0] req_wdata_sh;

    assign accept = bus.req_valid && (state_q == StIdle);

    always_comb begin
        req_off  = bus.req_addr[OFF_W-1:0];
        size_msk = OFF_W'(size_lsb_mask(bus.req_size));
        req_exc  = (bus.req_size == SizeDword) && (DATA_W < 64);
`ifdef MISALIGN_EXC_EN
        align_off = req_off;
        req_exc   = req_exc || ((req_off & size_msk) != '0);
`else
        align_off = req_off & ~size_msk;
`endif
        req_byteen   = BE_W'(16'(be_mask(bus.req_size)) << align_off);
        req_wdata_sh = bus.req_wdata << {align_off, 3'b000};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.req_valid) state_d = req_exc ? StResp : StIssue;
            StIssue: if (bus.mem_gnt) state_d = we_q ? StResp : StWait;
            StWait:  if (bus.mem_rvalid) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            exc_q    <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= '0;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                uns_q    <= bus.req_uns;
                size_q   <= bus.req_size;
                exc_q    <= req_exc;
                off_q    <= align_off;
                addr_q   <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                byteen_q <= req_byteen;
                wdata_q  <= req_wdata_sh;
                rdata_q  <= '0;
            end
            if ((state_q == StWait) && bus.mem_rvalid) begin
                rdata_q <= load_data;
            end
        end
    end

    lane_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_lane_align (
        .data   (bus.mem_rdata),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (load_data)
    );

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.mem_req    = (state_q == StIssue);
    assign bus.mem_we     = (state_q == StIssue) && we_q;
    assign bus.mem_byteen = (state_q == StIssue) ? byteen_q : '0;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_exc    = (state_q == StResp) && exc_q;
    assign bus.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_op_unit.sv
// Scoreboard bench for mem_op_unit: 32-bit and 64-bit instances, directed vectors,
// expected memory requests and responses queued by stimulus and checked by monitors.
module tb_mem_op_unit;
    import mem_op_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_op_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    mem_op_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    mem_op_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
    mem_op_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

    typedef struct { logic [63:0] rdata; logic exc; int lat; int acc; } rsp_t;
    typedef struct { logic [31:0] addr; logic [7:0] be; logic [63:0] wd; logic we; } mem_t;

    rsp_t rsp_q32[$], rsp_q64[$];
    mem_t mem_q32[$], mem_q64[$];

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    int          gnt_hold32 = 0;
    bit          auto32 = 1'b1;
    bit          ld_pend32 = 1'b0, ld_pend64 = 1'b0;
    logic [31:0] rdata32 = '0;
    logic [63:0] rdata64 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: got an event, expected none / in time", name);
    endtask

    // Memory models: grant after an optional hold, return load data one cycle after grant.
    initial begin
        b32.mem_gnt = 1'b0; b32.mem_rvalid = 1'b0; b32.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (auto32) begin
                b32.mem_rvalid = 1'b0;
                if (ld_pend32) begin
                    b32.mem_rvalid = 1'b1; b32.mem_rdata = rdata32; ld_pend32 = 1'b0;
                end
                b32.mem_gnt = 1'b0;
                if (b32.mem_req) begin
                    if (gnt_hold32 > 0) gnt_hold32--;
                    else begin b32.mem_gnt = 1'b1; ld_pend32 = !b32.mem_we; end
                end
            end
        end
    end

    initial begin
        b64.mem_gnt = 1'b0; b64.mem_rvalid = 1'b0; b64.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            b64.mem_rvalid = 1'b0;
            if (ld_pend64) begin
                b64.mem_rvalid = 1'b1; b64.mem_rdata = rdata64; ld_pend64 = 1'b0;
            end
            b64.mem_gnt = 1'b0;
            if (b64.mem_req) begin
                b64.mem_gnt = 1'b1; ld_pend64 = !b64.mem_we;
            end
        end
    end

    // Monitors
    always @(negedge clk) begin
        rsp_t e;
        mem_t m;
        if (b32.rsp_valid && b32.rsp_ready) begin
            if (rsp_q32.size() == 0) flag("rsp32_unexpected");
            else begin
                e = rsp_q32.pop_front();
                check("rsp32_rdata", 64'(b32.rsp_rdata), e.rdata);
                check("rsp32_exc", 64'(b32.rsp_exc), 64'(e.exc));
                if (e.lat > 0) check("rsp32_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
        if (b32.mem_req && b32.mem_gnt) begin
            if (mem_q32.size() == 0) flag("mem32_unexpected");
            else begin
                m = mem_q32.pop_front();
                check("mem32_addr", 64'(b32.mem_addr), 64'(m.addr));
                check("mem32_byteen", 64'(b32.mem_byteen), 64'(m.be));
                check("mem32_wdata", 64'(b32.mem_wdata), m.wd);
                check("mem32_we", 64'(b32.mem_we), 64'(m.we));
            end
        end
        if (b64.rsp_valid && b64.rsp_ready) begin
            if (rsp_q64.size() == 0) flag("rsp64_unexpected");
            else begin
                e = rsp_q64.pop_front();
                check("rsp64_rdata", b64.rsp_rdata, e.rdata);
                check("rsp64_exc", 64'(b64.rsp_exc), 64'(e.exc));
                if (e.lat > 0) check("rsp64_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
        if (b64.mem_req && b64.mem_gnt) begin
            if (mem_q64.size() == 0) flag("mem64_unexpected");
            else begin
                m = mem_q64.pop_front();
                check("mem64_addr", 64'(b64.mem_addr), 64'(m.addr));
                check("mem64_byteen", 64'(b64.mem_byteen), 64'(m.be));
                check("mem64_wdata", b64.mem_wdata, m.wd);
                check("mem64_we", 64'(b64.mem_we), 64'(m.we));
            end
        end
    end

    task automatic req32(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrd,
                         input bit has_mem, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_rd, input logic e_exc,
                         input int lat, input int hold);
        int n;
        gnt_hold32 = hold;
        rdata32    = mrd;
        n = 0;
        while (!b32.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!b32.req_ready) flag("req32_ready_timeout");
        b32.req_valid = 1'b1; b32.req_we = we; b32.req_size = sz; b32.req_uns = uns;
        b32.req_addr  = addr; b32.req_wdata = wdata;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        rsp_q32.push_back('{rdata: 64'(e_rd), exc: e_exc, lat: lat, acc: cyc});
        if (has_mem) mem_q32.push_back('{addr: e_addr, be: 8'(e_be), wd: 64'(e_wd), we: we});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_mem_req", 64'(b32.mem_req), 64'(1));
            check("hold_req_ready", 64'(b32.req_ready), 64'(0));
            check("hold_mem_addr", 64'(b32.mem_addr), 64'(e_addr));
            check("hold_mem_byteen", 64'(b32.mem_byteen), 64'(e_be));
            check("hold_mem_wdata", 64'(b32.mem_wdata), 64'(e_wd));
            check("hold_mem_we", 64'(b32.mem_we), 64'(we));
        end
        n = 0;
        while ((rsp_q32.size() != 0 || mem_q32.size() != 0) && n < 50) begin
            @(posedge clk); n++;
        end
        if (rsp_q32.size() != 0 || mem_q32.size() != 0) begin
            flag("req32_response_timeout");
            rsp_q32.delete(); mem_q32.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic req64(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] mrd,
                         input logic [31:0] e_addr, input logic [7:0] e_be, input logic [63:0] e_wd,
                         input logic [63:0] e_rd, input int lat);
        int n;
        rdata64 = mrd;
        n = 0;
        while (!b64.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!b64.req_ready) flag("req64_ready_timeout");
        b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = sz; b64.req_uns = uns;
        b64.req_addr  = addr; b64.req_wdata = wdata;
        @(posedge clk); #1;
        b64.req_valid = 1'b0;
        rsp_q64.push_back('{rdata: e_rd, exc: 1'b0, lat: lat, acc: cyc});
        mem_q64.push_back('{addr: e_addr, be: e_be, wd: e_wd, we: we});
        n = 0;
        while ((rsp_q64.size() != 0 || mem_q64.size() != 0) && n < 50) begin
            @(posedge clk); n++;
        end
        if (rsp_q64.size() != 0 || mem_q64.size() != 0) begin
            flag("req64_response_timeout");
            rsp_q64.delete(); mem_q64.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        b32.req_valid = 1'b0; b32.req_we = 1'b0; b32.req_size = 2'd0; b32.req_uns = 1'b0;
        b32.req_addr = '0; b32.req_wdata = '0; b32.rsp_ready = 1'b1;
        b64.req_valid = 1'b0; b64.req_we = 1'b0; b64.req_size = 2'd0; b64.req_uns = 1'b0;
        b64.req_addr = '0; b64.req_wdata = '0; b64.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_req_ready", 64'(b32.req_ready), 64'(1));
        check("reset_rsp_valid", 64'(b32.rsp_valid), 64'(0));
        check("reset_rsp_exc", 64'(b32.rsp_exc), 64'(0));
        check("reset_rsp_rdata", 64'(b32.rsp_rdata), 64'(0));
        check("reset_mem_req", 64'(b32.mem_req), 64'(0));
        check("reset_mem_we", 64'(b32.mem_we), 64'(0));
        check("reset_mem_byteen", 64'(b32.mem_byteen), 64'(0));
        check("reset64_mem_byteen", 64'(b64.mem_byteen), 64'(0));
        @(posedge clk); #1;

        //    we sz         uns addr        wdata          mem rdata       mem addr      be       wdata          rsp rdata     exc lat hold
        req32(1, SizeByte,  0, 32'h1003, 32'hAB,       32'h0,         1, 32'h1000, 4'b1000, 32'hAB00_0000, 32'h0,         0, 2, 0);
        req32(0, SizeHalf,  0, 32'h2002, 32'h0,        32'h8001_1234, 1, 32'h2000, 4'b1100, 32'h0,         32'hFFFF_8001, 0, 3, 0);
        req32(0, SizeHalf,  1, 32'h2002, 32'h0,        32'h8001_1234, 1, 32'h2000, 4'b1100, 32'h0,         32'h0000_8001, 0, 3, 0);
        req32(0, SizeByte,  0, 32'h41,   32'h0,        32'h1234_F678, 1, 32'h40,   4'b0010, 32'h0,         32'hFFFF_FFF6, 0, 3, 0);
        req32(0, SizeByte,  1, 32'h43,   32'h0,        32'h9C00_0000, 1, 32'h40,   4'b1000, 32'h0,         32'h0000_009C, 0, 3, 0);
        req32(0, SizeHalf,  0, 32'h44,   32'h0,        32'hABCD_7FFF, 1, 32'h44,   4'b0011, 32'h0,         32'h0000_7FFF, 0, 3, 0);
        req32(0, SizeWord,  0, 32'h100,  32'h0,        32'hDEAD_BEEF, 1, 32'h100,  4'b1111, 32'h0,         32'hDEAD_BEEF, 0, 3, 0);
        req32(1, SizeHalf,  0, 32'h22,   32'hBEEF,     32'h0,         1, 32'h20,   4'b1100, 32'hBEEF_0000, 32'h0,         0, 2, 0);
        req32(1, SizeWord,  0, 32'h30,   32'h1234_5678, 32'h0,        1, 32'h30,   4'b1111, 32'h1234_5678, 32'h0,         0, 2, 0);
        req32(0, SizeDword, 0, 32'h8,    32'h0,        32'h0,         0, 32'h0,    4'b0000, 32'h0,         32'h0,         1, 1, 0);
`ifdef MISALIGN_EXC_EN
        req32(0, SizeWord,  0, 32'h3001, 32'h0,        32'hCAFE_F00D, 0, 32'h0,    4'b0000, 32'h0,         32'h0,         1, 1, 0);
        req32(1, SizeHalf,  0, 32'h51,   32'h1234,     32'h0,         0, 32'h0,    4'b0000, 32'h0,         32'h0,         1, 1, 0);
`else
        req32(0, SizeWord,  0, 32'h3001, 32'h0,        32'hCAFE_F00D, 1, 32'h3000, 4'b1111, 32'h0,         32'hCAFE_F00D, 0, 3, 0);
        req32(1, SizeHalf,  0, 32'h51,   32'h1234,     32'h0,         1, 32'h50,   4'b0011, 32'h0000_1234, 32'h0,         0, 2, 0);
`endif
        req32(1, SizeByte,  0, 32'h62,   32'h5A,       32'h0,         1, 32'h60,   4'b0100, 32'h005A_0000, 32'h0,         0, 0, 5);

        // Response back-pressure: rsp_ready held low for several cycles.
        b32.rsp_ready = 1'b0;
        fork
            begin repeat (8) @(posedge clk); #1; b32.rsp_ready = 1'b1; end
        join_none
        req32(0, SizeByte,  1, 32'h80,   32'h0,        32'h0000_00E5, 1, 32'h80,   4'b0001, 32'h0,         32'h0000_00E5, 0, 0, 0);

        //    we sz         uns addr     wdata                   mem rdata               mem addr  be     wdata                   rsp rdata               lat
        req64(0, SizeDword, 0, 32'h8,  64'h0,                  64'h0123_4567_89AB_CDEF, 32'h8,  8'hFF, 64'h0,                  64'h0123_4567_89AB_CDEF, 3);
        req64(0, SizeWord,  0, 32'h14, 64'h0,                  64'h8765_4321_0000_0000, 32'h10, 8'hF0, 64'h0,                  64'hFFFF_FFFF_8765_4321, 3);
        req64(1, SizeByte,  0, 32'h25, 64'hAB,                 64'h0,                   32'h20, 8'h20, 64'h0000_AB00_0000_0000, 64'h0,                   2);
        req64(0, SizeHalf,  1, 32'h0E, 64'h0,                  64'hF00D_0000_0000_0000, 32'h8,  8'hC0, 64'h0,                  64'h0000_0000_0000_F00D, 3);
        req64(1, SizeDword, 0, 32'h18, 64'hFEDC_BA98_7654_3210, 64'h0,                  32'h18, 8'hFF, 64'hFEDC_BA98_7654_3210, 64'h0,                   2);

        // Reset while waiting for load data; the late mem_rvalid must be dropped.
        auto32 = 1'b0;
        b32.mem_gnt = 1'b0; b32.mem_rvalid = 1'b0;
        b32.req_valid = 1'b1; b32.req_we = 1'b0; b32.req_size = SizeWord; b32.req_uns = 1'b0;
        b32.req_addr = 32'h70; b32.req_wdata = 32'h0;
        @(posedge clk); #1;
        b32.req_valid = 1'b0;
        mem_q32.push_back('{addr: 32'h70, be: 8'h0F, wd: 64'h0, we: 1'b0});
        b32.mem_gnt = 1'b1;
        @(posedge clk); #1;
        b32.mem_gnt = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("wait_req_ready", 64'(b32.req_ready), 64'(0));
        check("wait_mem_granted", 64'(mem_q32.size()), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        b32.mem_rvalid = 1'b1; b32.mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        check("post_reset_req_ready", 64'(b32.req_ready), 64'(1));
        check("post_reset_rsp_valid", 64'(b32.rsp_valid), 64'(0));
        @(posedge clk); #1;
        b32.mem_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("late_rvalid_rsp_valid", 64'(b32.rsp_valid), 64'(0));
            check("late_rvalid_mem_req", 64'(b32.mem_req), 64'(0));
        end
        check("late_rvalid_req_ready", 64'(b32.req_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
